// File: rtl/counter_array_pkg.sv
// counter_array_pkg: shared sizing constants and types for the counter bank
package counter_array_pkg;
   localparam int N_CNT = 8;
   localparam int CNT_W = 5;
   localparam int ADDR_W = $clog2(N_CNT);
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/counter_array_cell.sv
// counter_array_cell: one saturating up/down counter register
module counter_array_cell
   import counter_array_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output cnt_t value
);
   // step up or down only when exactly one request is present and the limit is not yet reached
   always_ff @(posedge clk) begin
      if (rst) value <= '0;
      else if (inc && !dec && value != '1) value <= value + CNT_W'(1);
      else if (dec && !inc && value != '0) value <= value - CNT_W'(1);
   end
endmodule

// File: rtl/counter_array.sv
// counter_array: bank of independent saturating up/down counters with shared inc/dec ports
module counter_array
   import counter_array_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              incr,
   input  logic [ADDR_W-1:0] incr_addr,
   input  logic              decr,
   input  logic [ADDR_W-1:0] decr_addr,
   output logic [CNT_W-1:0]  cnt [0:N_CNT-1]
);
   logic [N_CNT-1:0] inc_vec;
   logic [N_CNT-1:0] dec_vec;
   // one-hot decode of both strobes; an address with no matching counter selects nothing
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 0; i < N_CNT; i++) begin
         inc_vec[i] = incr && incr_addr == ADDR_W'(i);
         dec_vec[i] = decr && decr_addr == ADDR_W'(i);
      end
   end
   for (genvar g = 0; g < N_CNT; g++) begin : g_cell
      counter_array_cell u_cell (
         .clk   (clk),
         .rst   (rst),
         .inc   (inc_vec[g]),
         .dec   (dec_vec[g]),
         .value (cnt[g])
      );
   end
endmodule

// File: tb/tb_counter_array.sv
// tb_counter_array: randomized scoreboard bench for the counter bank
module tb_counter_array;
   import counter_array_pkg::*;
   localparam int N = N_CNT;
   localparam int W = CNT_W;
   localparam int MAXV = (1 << W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              incr = 1'b0;
   logic [ADDR_W-1:0] incr_addr = '0;
   logic              decr = 1'b0;
   logic [ADDR_W-1:0] decr_addr = '0;
   logic [W-1:0]      cnt [0:N-1];

   int checks = 0;
   int passed = 0;
   int model [N];
   logic [N*W-1:0] exp_q [$];

   counter_array dut (
      .clk       (clk),
      .rst       (rst),
      .incr      (incr),
      .incr_addr (incr_addr),
      .decr      (decr),
      .decr_addr (decr_addr),
      .cnt       (cnt)
   );

   always #5 clk = ~clk;

   // drive one cycle of stimulus and push the state the bank must show after the next edge
   task automatic step(input logic r, input logic i, input int ia, input logic d, input int da);
      logic [N*W-1:0] e;
      @(negedge clk);
      rst = r;
      incr = i;
      incr_addr = ADDR_W'(ia);
      decr = d;
      decr_addr = ADDR_W'(da);
      if (r) begin
         for (int k = 0; k < N; k++) model[k] = 0;
      end else if (!(i && d && ia == da)) begin
         if (i && ia < N) model[ia] = (model[ia] + 1 > MAXV) ? MAXV : model[ia] + 1;
         if (d && da < N) model[da] = (model[da] - 1 < 0) ? 0 : model[da] - 1;
      end
      for (int k = 0; k < N; k++) e[k*W +: W] = W'(model[k]);
      exp_q.push_back(e);
   endtask

   // monitor: every cycle the bank presents a full new state; compare it with the oldest expectation
   initial begin
      logic [N*W-1:0] e;
      int bad;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bad = -1;
            for (int k = N - 1; k >= 0; k--) if (cnt[k] !== e[k*W +: W]) bad = k;
            checks++;
            if (bad < 0) passed++;
            else $display("FAIL cnt[%0d] at %0t: got %0d expected %0d", bad, $time, cnt[bad], e[bad*W +: W]);
         end
      end
   end

   initial begin
      int wait_cycles;
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 1, 2, 1, 2);
      repeat (5) step(0, 1, 2, 0, 0);
      step(0, 1, 2, 1, 2);
      step(0, 1, 3, 1, 0);
      repeat (35) step(0, 1, 7, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 1, 7, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 300; c++) begin
            int lo = (p % 2 == 0) ? 0 : 2;
            int hi = (p % 2 == 0) ? 2 : 7;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < ((p % 2 == 0) ? 8 : 3), $urandom_range(lo, hi),
                 $urandom_range(0, 9) < ((p % 2 == 0) ? 3 : 8), $urandom_range(lo, hi));
         end
      end
      @(negedge clk);
      incr = 1'b0;
      decr = 1'b0;
      rst = 1'b0;
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
